// File: rtl/accel_input_fetch_if.sv
// Signal bundle between the input fetch block, its beat source and the PE array.
// master is the fetch block; slave is whatever sits around it (source, PE array, controller).
interface accel_input_fetch_if #(
  parameter int BIT_WIDTH   = 8,
  parameter int NUM_CHANNEL = 3,
  parameter int NUM_KERNEL  = 4,
  parameter int CNT_WIDTH   = 16
);
  localparam int PIX_W = BIT_WIDTH * NUM_CHANNEL;
  localparam int WGT_W = PIX_W * NUM_KERNEL;

  logic                 i_start;
  logic [CNT_WIDTH-1:0] i_num_pixel;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_err;

  logic                 o_data_req;
  logic [PIX_W-1:0]     i_data;
  logic                 i_data_val;
  logic [WGT_W-1:0]     i_weight;
  logic                 i_weight_val;

  logic [PIX_W-1:0]     o_pe_data;
  logic [WGT_W-1:0]     o_pe_weight;
  logic                 o_pe_val;
  logic                 i_pe_ready;

  modport master (
    input  i_start, i_num_pixel, i_data, i_data_val, i_weight, i_weight_val, i_pe_ready,
    output o_busy, o_done, o_err, o_data_req, o_pe_data, o_pe_weight, o_pe_val
  );

  modport slave (
    output i_start, i_num_pixel, i_data, i_data_val, i_weight, i_weight_val, i_pe_ready,
    input  o_busy, o_done, o_err, o_data_req, o_pe_data, o_pe_weight, o_pe_val
  );
endinterface

// File: rtl/accel_input_fetch.sv
// Input fetch for the accelerator core: requests pixel/weight beats, buffers them in a
// credit-protected FWFT FIFO and hands them to the PE array over valid/ready.
module accel_input_fetch #(
  parameter int BIT_WIDTH   = 8,
  parameter int NUM_CHANNEL = 3,
  parameter int NUM_KERNEL  = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                rst,
  accel_input_fetch_if.master bus
);
  localparam int PIX_W  = BIT_WIDTH * NUM_CHANNEL;
  localparam int WGT_W  = PIX_W * NUM_KERNEL;
  localparam int BEAT_W = PIX_W + WGT_W;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] num_q, issued_q, rcv_q, out_q;
  logic                 req_d1;
  logic                 err_q;

  logic [BEAT_W-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        fifo_cnt;

  logic                 start_acc;
  logic                 req;
  logic                 credit_ok;
  logic                 beat_ok, beat_bad;
  logic                 push, pop;
  logic                 pe_val;
  logic [BEAT_W-1:0]    head;

  assign start_acc = (state_q == IDLE) && bus.i_start;

  // A beat in flight (req_d1) already owns a FIFO slot, so credits never overcommit.
  assign credit_ok = (fifo_cnt + CW'(req_d1)) < CW'(FIFO_DEPTH);
  assign req       = (state_q == RUN) && (issued_q < num_q) && credit_ok;

  assign beat_ok  = req_d1 && bus.i_data_val && bus.i_weight_val;
  assign beat_bad = req_d1 && !(bus.i_data_val && bus.i_weight_val);
  assign push     = beat_ok;
  assign pe_val   = (fifo_cnt != '0);
  assign pop      = pe_val && bus.i_pe_ready;
  assign head     = mem[rd_ptr];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.i_start) state_d = (bus.i_num_pixel != '0) ? RUN : DONE;
      RUN:  if ((out_q == num_q) && (rcv_q == num_q)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request stage: req_d1 marks the cycle the source's registered response is due.
  always_ff @(posedge clk) begin
    if (rst) req_d1 <= 1'b0;
    else     req_d1 <= req;
  end

  // A dropped beat gives its request back so it is issued again.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_q    <= '0;
      issued_q <= '0;
      rcv_q    <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else if (start_acc) begin
      num_q    <= bus.i_num_pixel;
      issued_q <= '0;
      rcv_q    <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      issued_q <= issued_q + CNT_WIDTH'(req) - CNT_WIDTH'(beat_bad);
      rcv_q    <= rcv_q + CNT_WIDTH'(push);
      out_q    <= out_q + CNT_WIDTH'(pop);
      err_q    <= err_q | beat_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Capture stage: storage holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.i_weight, bus.i_data};
  end

  // Head is masked while empty so the outputs read zero after reset.
  assign bus.o_pe_val    = pe_val;
  assign bus.o_pe_data   = pe_val ? head[PIX_W-1:0]      : '0;
  assign bus.o_pe_weight = pe_val ? head[BEAT_W-1:PIX_W] : '0;
  assign bus.o_data_req  = req;
  assign bus.o_busy      = (state_q == RUN);
  assign bus.o_done      = (state_q == DONE);
  assign bus.o_err       = err_q;
endmodule
